ppm_freq_estimator: RTL and testbench

Parametrised successor to the preamble frequency-recovery FSM in the PPM CDR path. Measures the clock-cycle spacing between preamble pulses, which nominally occur one per symbol. It averages 2^AVG_LOG2 intervals per window and reports a signed frequency error per window. It rejects glitch pulses, times out on missing pulses, and declares lock after LOCK_WINDOWS consecutive in-tolerance windows.

---
 rtl/ppm_freq_estimator_pkg.sv | 33 +++
 rtl/ppm_freq_estimator_if.sv | 29 ++
 rtl/ppm_sat_counter.sv | 24 ++
 rtl/ppm_freq_estimator.sv | 194 +++++++++++++++++++
 tb/tb_ppm_freq_estimator.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppm_freq_estimator_pkg.sv
// Shared definitions for the PPM preamble frequency estimator.
// Holds the FSM state encoding, a ceiling-log2 helper used to size the
// counters, and the glitch / timeout gap limits derived from the nominal
// symbol length.
package ppm_freq_estimator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_SCAN    = 2'b01,
      ST_MEASURE = 2'b10,
      ST_LOCKED  = 2'b11
   } state_t;

   function automatic int ceil_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Shortest spacing accepted as a real pulse; anything closer is a glitch.
   function automatic int min_gap(input int symbol_chips);
      return symbol_chips / 2;
   endfunction

   // Counter value at which a missing pulse is declared.
   function automatic int max_gap(input int symbol_chips);
      return 4 * symbol_chips - 1;
   endfunction

endpackage

// File: rtl/ppm_freq_estimator_if.sv
// Signal bundle between the estimator and its user.
//   enable, din, pulse_threshold : run control and chip sample (into estimator)
//   pulse_detected, freq_err, err_valid, locked, timeout, glitch_count :
//                                  status back from the estimator
// master = user side, slave = estimator side.
interface ppm_freq_estimator_if #(
   parameter int CHIP_BITS = 1,
   parameter int ERR_W     = 10
);
   logic                    enable;
   logic [CHIP_BITS-1:0]    din;
   logic [CHIP_BITS-1:0]    pulse_threshold;
   logic                    pulse_detected;
   logic signed [ERR_W-1:0] freq_err;
   logic                    err_valid;
   logic                    locked;
   logic                    timeout;
   logic [7:0]              glitch_count;

   modport master (
      output enable, din, pulse_threshold,
      input  pulse_detected, freq_err, err_valid, locked, timeout, glitch_count
   );

   modport slave (
      input  enable, din, pulse_threshold,
      output pulse_detected, freq_err, err_valid, locked, timeout, glitch_count
   );
endinterface

// File: rtl/ppm_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
//   clk, reset : clock and synchronous active-high reset
//   clr        : clear to zero (wins over inc)
//   inc        : advance by one unless already saturated
//   count      : current value
module ppm_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ppm_freq_estimator.sv
// Preamble frequency estimator for the PPM CDR path.
// Times the spacing between preamble pulses, sums 2^AVG_LOG2 intervals per
// window and reports the window sum minus the nominal sum as a signed error.
// Glitch pulses (too close) are counted and ignored; a missing pulse times
// out back to SCAN; LOCK_WINDOWS consecutive in-tolerance windows lock.
//
// Ports:
//   clk, reset : clock (one chip per cycle), synchronous active-high reset
//   bus        : ppm_freq_estimator_if.slave (enable/din/threshold in,
//                pulse/error/lock/timeout/glitch status out)
// Build option PPM_FREQ_SC_EN adds scan-chain debug outputs that mirror the
// internal state, interval counter, accumulator, window and good counters.
//
// state   | meaning
// IDLE    | estimator disabled
// SCAN    | waiting for first reference pulse
// MEASURE | timing intervals, not locked
// LOCKED  | timing intervals, frequency within tolerance
module ppm_freq_estimator
   import ppm_freq_estimator_pkg::*;
#(
   parameter int CHIP_BITS    = 1,
   parameter int SYMBOL_CHIPS = 16,
   parameter int AVG_LOG2     = 2,
   parameter int LOCK_TOL     = 2,
   parameter int LOCK_WINDOWS = 2,
   localparam int CW    = ceil_log2(SYMBOL_CHIPS),
   localparam int CNT_W = CW + 2,
   localparam int AW    = CW + 3 + AVG_LOG2,
   localparam int EW    = CW + 4 + AVG_LOG2,
   localparam int GW    = ceil_log2(LOCK_WINDOWS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   ppm_freq_estimator_if.slave  bus
`ifdef PPM_FREQ_SC_EN
   ,
   output logic [1:0]           FREQ_state_SC,
   output logic [CNT_W-1:0]     FREQ_interval_count_SC,
   output logic [AW-1:0]        FREQ_acc_SC,
   output logic [AVG_LOG2-1:0]  FREQ_window_count_SC,
   output logic [GW-1:0]        FREQ_good_count_SC
`endif
);

   localparam int IW     = CW + 3;   // holds an interval of up to 4*SYMBOL_CHIPS
   localparam int NOM    = SYMBOL_CHIPS << AVG_LOG2;
   localparam int WINDOW = 1 << AVG_LOG2;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt;
   logic [AW-1:0]           acc;
   logic [AVG_LOG2-1:0]     win_cnt;
   logic [GW-1:0]           good_cnt;
   logic signed [EW-1:0]    freq_err_q;
   logic                    err_valid_q, locked_q, timeout_q;

   logic                    pulse;
   logic [IW-1:0]           interval;
   logic [AW-1:0]           acc_sum;
   logic signed [EW-1:0]    err_calc, err_abs;
   logic                    in_tol, win_done;
   logic                    accept, glitch, cnt_clr, cnt_inc, timed_out;

   assign pulse    = bus.enable && (bus.din >= bus.pulse_threshold);
   assign interval = IW'(cnt) + IW'(1);
   assign acc_sum  = acc + AW'(interval);
   // acc_sum is unsigned and narrower than EW, so zero-extension keeps it positive.
   assign err_calc = $signed(EW'(acc_sum)) - $signed(EW'(NOM));
   assign err_abs  = err_calc[EW-1] ? -err_calc : err_calc;
   assign in_tol   = (err_abs <= $signed(EW'(LOCK_TOL)));
   assign win_done = accept && (win_cnt == AVG_LOG2'(WINDOW - 1));

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      glitch    = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      timed_out = 1'b0;
      if (!bus.enable) begin
         state_d = ST_IDLE;
         cnt_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_SCAN;
            ST_SCAN: begin
               if (pulse) begin
                  state_d = ST_MEASURE;
                  cnt_clr = 1'b1;
               end
            end
            ST_MEASURE, ST_LOCKED: begin
               if (pulse) begin
                  if (interval < IW'(min_gap(SYMBOL_CHIPS))) begin
                     // glitch: keep timing from the last real pulse
                     glitch  = 1'b1;
                     cnt_inc = 1'b1;
                  end else begin
                     accept  = 1'b1;
                     cnt_clr = 1'b1;
                     if (win_cnt == AVG_LOG2'(WINDOW - 1)) begin
                        if (in_tol) begin
                           if ((state_q == ST_MEASURE) &&
                               (int'(good_cnt) + 1 >= LOCK_WINDOWS))
                              state_d = ST_LOCKED;
                        end else begin
                           state_d = ST_MEASURE;
                        end
                     end
                  end
               end else if (cnt == CNT_W'(max_gap(SYMBOL_CHIPS))) begin
                  timed_out = 1'b1;
                  cnt_clr   = 1'b1;
                  state_d   = ST_SCAN;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc         <= '0;
         win_cnt     <= '0;
         good_cnt    <= '0;
         freq_err_q  <= '0;
         err_valid_q <= 1'b0;
         locked_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         err_valid_q <= win_done;
         timeout_q   <= timed_out;
         locked_q    <= (state_d == ST_LOCKED);
         if (!bus.enable || timed_out) begin
            acc      <= '0;
            win_cnt  <= '0;
            good_cnt <= '0;
         end else if (accept) begin
            if (win_done) begin
               acc        <= '0;
               win_cnt    <= '0;
               freq_err_q <= err_calc;
               if (!in_tol)
                  good_cnt <= '0;
               else if (int'(good_cnt) < LOCK_WINDOWS)
                  good_cnt <= good_cnt + 1'b1;
            end else begin
               acc     <= acc_sum;
               win_cnt <= win_cnt + 1'b1;
            end
         end
      end
   end

   ppm_sat_counter #(.WIDTH(CNT_W)) u_interval_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (cnt)
   );

   ppm_sat_counter #(.WIDTH(8)) u_glitch_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (glitch),
      .count (bus.glitch_count)
   );

   assign bus.pulse_detected = pulse;
   assign bus.freq_err       = freq_err_q;
   assign bus.err_valid      = err_valid_q;
   assign bus.locked         = locked_q;
   assign bus.timeout        = timeout_q;

`ifdef PPM_FREQ_SC_EN
   assign FREQ_state_SC          = state_q;
   assign FREQ_interval_count_SC = cnt;
   assign FREQ_acc_SC            = acc;
   assign FREQ_window_count_SC   = win_cnt;
   assign FREQ_good_count_SC     = good_cnt;
`endif

endmodule

// File: tb/tb_ppm_freq_estimator.sv
// Testbench for ppm_freq_estimator: directed pulse trains followed by random
// spacing, every cycle compared against an interval-list reference model.
module tb_ppm_freq_estimator;

   localparam int SC   = 16;
   localparam int AL   = 2;
   localparam int TOL  = 2;
   localparam int LW   = 2;
   localparam int CB   = 1;
   localparam int EW   = 4 + 4 + AL;
   localparam int NWIN = 1 << AL;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ppm_freq_estimator_if #(.CHIP_BITS(CB), .ERR_W(EW)) bus ();

`ifdef PPM_FREQ_SC_EN
   logic [1:0]    sc_state;
   logic [5:0]    sc_cnt;
   logic [8:0]    sc_acc;
   logic [AL-1:0] sc_win;
   logic [1:0]    sc_good;
`endif

   ppm_freq_estimator #(
      .CHIP_BITS(CB), .SYMBOL_CHIPS(SC), .AVG_LOG2(AL),
      .LOCK_TOL(TOL), .LOCK_WINDOWS(LW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef PPM_FREQ_SC_EN
      ,
      .FREQ_state_SC          (sc_state),
      .FREQ_interval_count_SC (sc_cnt),
      .FREQ_acc_SC            (sc_acc),
      .FREQ_window_count_SC   (sc_win),
      .FREQ_good_count_SC     (sc_good)
`endif
   );

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: mode 0 = off, 1 = hunting first pulse, 2 = tracking
   int m_mode = 0;
   int m_since = 0;
   int m_iv[$];
   int m_good = 0;
   bit m_lock = 0;
   int m_err = 0;
   bit m_ev = 0;
   bit m_to = 0;
   int m_gl = 0;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit p);
      int sum;
      int mag;
      m_ev = 0;
      m_to = 0;
      if (reset) begin
         m_mode = 0; m_since = 0; m_iv.delete(); m_good = 0;
         m_lock = 0; m_err = 0; m_gl = 0;
         return;
      end
      if (!bus.enable) begin
         m_mode = 0; m_iv.delete(); m_good = 0; m_lock = 0;
         return;
      end
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (p) begin
            m_mode = 2;
            m_since = 0;
         end
      end else begin
         m_since++;
         if (p && (m_since < SC / 2)) begin
            if (m_gl < 255) m_gl++;
         end else if (p) begin
            m_iv.push_back(m_since);
            m_since = 0;
            if (m_iv.size() == NWIN) begin
               sum = 0;
               foreach (m_iv[i]) sum += m_iv[i];
               m_err = sum - SC * NWIN;
               m_ev = 1;
               m_iv.delete();
               mag = (m_err < 0) ? -m_err : m_err;
               if (mag <= TOL) begin
                  m_good++;
                  m_lock = (m_good >= LW);
               end else begin
                  m_good = 0;
                  m_lock = 0;
               end
            end
         end else if (m_since == 4 * SC) begin
            m_to = 1; m_mode = 1; m_iv.delete(); m_good = 0; m_lock = 0;
         end
      end
   endtask

   task automatic tick();
      bit p;
      #1;
      p = bus.enable && (bus.din >= bus.pulse_threshold);
      check("pulse_detected", bus.pulse_detected, p);
      model_step(p);
      @(posedge clk);
      #1;
      check("err_valid", bus.err_valid, m_ev);
      check("timeout", bus.timeout, m_to);
      check("locked", bus.locked, m_lock);
      check("freq_err", $signed(bus.freq_err), m_err);
      check("glitch_count", bus.glitch_count, m_gl);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.din = '0;
         tick();
      end
   endtask

   task automatic pulse_after(input int gap);
      for (int i = 1; i < gap; i++) begin
         bus.din = '0;
         tick();
      end
      bus.din = 1'b1;
      tick();
      bus.din = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic restart();
      bus.enable = 1'b0;
      idle(2);
      bus.enable = 1'b1;
      idle(2);
      pulse_after(1);
   endtask

   int to_at;
   int gap;

   initial begin
      reset = 1'b1;
      bus.enable = 1'b0;
      bus.din = '0;
      bus.pulse_threshold = 1'b1;
      idle(3);
      check("rst_freq_err", $signed(bus.freq_err), 0);
      check("rst_glitch", bus.glitch_count, 0);
      reset = 1'b0;

      // nominal spacing: first window at the 5th pulse, lock at the 9th
      restart();
      for (int k = 1; k <= 12; k++) begin
         pulse_after(16);
         if (k == 4) begin
            check("s1_first_valid", bus.err_valid, 1);
            check("s1_err_zero", $signed(bus.freq_err), 0);
         end
         if (k == 7) check("s1_not_yet_locked", bus.locked, 0);
         if (k == 8) check("s1_locked", bus.locked, 1);
      end

      // slow then fast spacing
      restart();
      for (int k = 1; k <= 8; k++) pulse_after(17);
      check("s2_err_plus4", $signed(bus.freq_err), 4);
      check("s2_no_lock", bus.locked, 0);
      for (int k = 1; k <= 8; k++) pulse_after(15);
      check("s2_err_minus4", $signed(bus.freq_err), -4);

      // lock, then drift out of tolerance
      restart();
      for (int k = 1; k <= 8; k++) pulse_after(16);
      check("s3_locked", bus.locked, 1);
      for (int k = 1; k <= 4; k++) pulse_after(18);
      check("s3_err_plus8", $signed(bus.freq_err), 8);
      check("s3_unlock", bus.locked, 0);
      check("s3_valid", bus.err_valid, 1);

      // glitch 3 cycles after a pulse
      do_reset();
      restart();
      pulse_after(16);
      pulse_after(3);
      check("s4_glitch_one", bus.glitch_count, 1);
      pulse_after(13);
      pulse_after(16);
      pulse_after(16);
      check("s4_err_zero", $signed(bus.freq_err), 0);

      // missing pulse timeout, then a pulse exactly on the limit
      restart();
      to_at = 0;
      for (int i = 1; i <= 70; i++) begin
         bus.din = '0;
         tick();
         if (bus.timeout === 1'b1) to_at = i;
      end
      check("s5_timeout_at", to_at, 64);
      pulse_after(1);
      pulse_after(64);
      check("s5_no_timeout", bus.timeout, 0);
      pulse_after(16);
      pulse_after(16);
      pulse_after(16);
      check("s5_err_long", $signed(bus.freq_err), 48);

      // enable dropped on the window-completing pulse
      restart();
      for (int k = 1; k <= 3; k++) pulse_after(16);
      idle(15);
      bus.enable = 1'b0;
      bus.din = 1'b1;
      tick();
      check("s6_no_valid", bus.err_valid, 0);
      bus.din = '0;
      tick();
      bus.enable = 1'b1;
      idle(2);
      pulse_after(1);
      pulse_after(16);
      pulse_after(7);
      reset = 1'b1;
      tick();
      check("s6_rst_err", $signed(bus.freq_err), 0);
      check("s6_rst_glitch", bus.glitch_count, 0);
      check("s6_rst_lock", bus.locked, 0);
      reset = 1'b0;

      // glitch counter saturation
      restart();
      for (int k = 0; k < 90; k++) begin
         pulse_after(2);
         pulse_after(2);
         pulse_after(2);
         pulse_after(10);
      end
      check("s7_glitch_sat", bus.glitch_count, 255);

      // random spacing with occasional enable drops and resets
      do_reset();
      restart();
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) gap = $urandom_range(15, 17);
         else gap = $urandom_range(2, 70);
         pulse_after(gap);
         if ($urandom_range(0, 29) == 0) begin
            bus.enable = 1'b0;
            idle($urandom_range(1, 3));
            bus.enable = 1'b1;
         end
         if ($urandom_range(0, 99) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
